// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-adder cell plus a carry flop, time-shared
// over all WIDTH bit positions, with valid/ready handshakes on both sides.
module serial_add_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             busy
);

   localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;

   logic             sum_bit;
   logic             carry_nx;
   logic [WIDTH-1:0] s_sr_nx;

   // Single shared full-adder cell on the LSBs of the operand shifters
   always_comb begin
      sum_bit  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
      carry_nx = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
      // Sum bits enter at the MSB; the widened shift keeps WIDTH=1 legal
      s_sr_nx  = WIDTH'({sum_bit, s_sr_q} >> 1);
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      carry_d = carry_q;
      count_d = count_q;
      s_d     = s_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = b;
               s_sr_d  = '0;
               carry_d = cin;
               count_d = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            s_sr_d  = s_sr_nx;
            carry_d = carry_nx;
            if (count_q == CNT_LAST) begin
               // Last bit: publish the completed sum and carry-out
               s_d     = s_sr_nx;
               cout_d  = carry_nx;
               state_d = DONE;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         carry_q <= carry_d;
         count_q <= count_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

   // Handshake flags decode the state register only
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign s         = s_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: transaction-level reference model checked every cycle,
// plus directed vectors with literal expectations (32-bit and 1-bit instances).
module tb_serial_add_seq;

   localparam int unsigned W = 32;
   localparam int          T = 10;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;

   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         cin       = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] s;
   logic         cout;
   logic         busy;

   logic         in_valid1  = 1'b0;
   logic         in_ready1;
   logic         a1         = 1'b0;
   logic         b1         = 1'b0;
   logic         cin1       = 1'b0;
   logic         out_valid1;
   logic         out_ready1 = 1'b1;
   logic         s1;
   logic         cout1;
   logic         busy1;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_en   = 1'b0;
   int  n_acc    = 0;
   int  n_xfer   = 0;
   time last_acc = 0;

   // Reference model state (transaction level: pending sum and a latency countdown)
   logic         m_ir   = 1'b1;
   logic         m_ov   = 1'b0;
   logic [W-1:0] m_s    = '0;
   logic         m_cout = 1'b0;
   logic [W:0]   m_pend = '0;
   int           m_left = 0;

   serial_add_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cout(cout), .busy(busy)
   );

   serial_add_seq #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .s(s1), .cout(cout1), .busy(busy1)
   );

   always #(T/2) clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ir = 1'b1; m_ov = 1'b0; m_s = '0; m_cout = 1'b0; m_left = 0; m_pend = '0;
      end else if (m_ir) begin
         if (in_valid) begin
            m_pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            m_ir   = 1'b0;
            m_left = W;
         end
      end else if (!m_ov) begin
         m_left--;
         if (m_left == 0) begin
            m_ov = 1'b1;
            {m_cout, m_s} = m_pend;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
         m_ir = 1'b1;
      end
   end

   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         n_acc++;
         last_acc = $time;
      end
      if (rst_n && out_valid && out_ready) n_xfer++;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_in_ready",  64'(in_ready),  64'(m_ir));
         chk("model_out_valid", 64'(out_valid), 64'(m_ov));
         chk("model_busy",      64'(busy),      64'(!m_ir));
         chk("model_s",         64'(s),         64'(m_s));
         chk("model_cout",      64'(cout),      64'(m_cout));
      end
   end

   task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      int start;
      int g;
      start = n_acc;
      g = 0;
      @(negedge clk);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      while (n_acc == start && g < 400) begin
         @(negedge clk);
         g++;
      end
      in_valid = 1'b0;
      chk("accept", 64'(n_acc - start), 64'(1));
   endtask

   task automatic wait_valid(input string nm, output int lat);
      int g;
      g = 0;
      while (!out_valid && g < 400) begin
         @(negedge clk);
         g++;
      end
      chk({nm, "_valid_seen"}, 64'(out_valid), 64'(1));
      lat = int'(($time - last_acc - time'(T/2)) / time'(T));
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (!in_ready && g < 400) begin
         @(negedge clk);
         g++;
      end
      chk("return_idle", 64'(in_ready), 64'(1));
   endtask

   initial begin
      int   lat;
      int   acc0;
      int   x0;
      int   g;
      time  t0;
      logic [1:0] exp1 [8];
      exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready",  64'(in_ready),  64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_busy",      64'(busy),      64'(0));
      chk("rst_s",         64'(s),         64'(0));
      chk("rst_cout",      64'(cout),      64'(0));
      chk_en = 1'b1;

      // All-ones plus carry-in wraps to zero with carry-out
      out_ready = 1'b1;
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      wait_valid("t1", lat);
      chk("t1_latency", 64'(lat), 64'(32));
      chk("t1_s",       64'(s),    64'(32'h0000_0000));
      chk("t1_cout",    64'(cout), 64'(1));
      chk("t1_model_s", 64'({m_cout, m_s}), 64'(33'h1_0000_0000));
      wait_idle();

      // Back-to-back with in_valid held high
      acc0 = n_acc;
      @(negedge clk);
      a = 32'd5; b = 32'd6; cin = 1'b1; in_valid = 1'b1;
      g = 0;
      while (n_acc == acc0 && g < 400) begin @(negedge clk); g++; end
      t0 = last_acc;
      a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0;
      wait_valid("t2a", lat);
      chk("t2a_s",    64'(s),    64'(32'h0000_000C));
      chk("t2a_cout", 64'(cout), 64'(0));
      chk("t2a_model_s", 64'(m_s), 64'(32'h0000_000C));
      g = 0;
      while (n_acc == acc0 + 1 && g < 400) begin @(negedge clk); g++; end
      in_valid = 1'b0;
      chk("t2_accepts",  64'(n_acc - acc0), 64'(2));
      chk("t2_interval", 64'((last_acc - t0) / time'(T)), 64'(34));
      wait_valid("t2b", lat);
      chk("t2b_s",    64'(s),    64'(32'h0000_0000));
      chk("t2b_cout", 64'(cout), 64'(1));
      wait_idle();

      // Backpressure window with ignored in_valid pulses
      out_ready = 1'b0;
      send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
      wait_valid("t3", lat);
      acc0 = n_acc;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t3_s_hold",    64'(s),         64'(32'h1010_1010));
         chk("t3_cout_hold", 64'(cout),      64'(0));
         chk("t3_in_ready",  64'(in_ready),  64'(0));
         chk("t3_out_valid", 64'(out_valid), 64'(1));
         in_valid = i[0];
         a = W'($urandom);
      end
      in_valid = 1'b0;
      x0 = n_xfer;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t3_xfer",     64'(n_xfer - x0), 64'(1));
      chk("t3_in_ready", 64'(in_ready),    64'(1));
      @(negedge clk);
      chk("t3_one_xfer", 64'(n_xfer - x0), 64'(1));
      chk("t3_no_accept", 64'(n_acc - acc0), 64'(0));

      // Reset in the middle of RUN
      x0 = n_xfer;
      send(32'h1234_5678, 32'h1111_1111, 1'b0);
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t4_in_ready",  64'(in_ready),  64'(1));
      chk("t4_out_valid", 64'(out_valid), 64'(0));
      chk("t4_busy",      64'(busy),      64'(0));
      chk("t4_s",         64'(s),         64'(0));
      chk("t4_cout",      64'(cout),      64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      send(32'd1, 32'd1, 1'b0);
      wait_valid("t4b", lat);
      chk("t4b_s",    64'(s),    64'(32'd2));
      chk("t4b_cout", 64'(cout), 64'(0));
      chk("t4_discarded", 64'(n_xfer - x0), 64'(0));
      wait_idle();

      // Random operands with random consumer stalls
      x0 = n_xfer;
      for (int k = 0; k < 1000; k++) begin
         acc0 = n_acc;
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
         in_valid = 1'b1;
         g = 0;
         while (n_acc == acc0 && g < 400) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            g++;
         end
         in_valid = 1'b0;
         if (n_acc == acc0) chk("t5_accept", 64'(n_acc - acc0), 64'(1));
      end
      out_ready = 1'b1;
      g = 0;
      while ((n_xfer - x0) != 1000 && g < 400) begin @(negedge clk); g++; end
      chk("t5_transfers", 64'(n_xfer - x0), 64'(1000));

      // One-bit instance: every input combination, one-cycle latency
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("w1_in_ready", 64'(in_ready1), 64'(1));
         a1 = i[2]; b1 = i[1]; cin1 = i[0]; in_valid1 = 1'b1;
         @(negedge clk);
         in_valid1 = 1'b0;
         chk("w1_run_valid", 64'(out_valid1), 64'(0));
         chk("w1_run_busy",  64'(busy1),      64'(1));
         @(negedge clk);
         chk("w1_valid", 64'(out_valid1), 64'(1));
         chk("w1_s",     64'(s1),         64'(exp1[i][0]));
         chk("w1_cout",  64'(cout1),      64'(exp1[i][1]));
         @(negedge clk);
         chk("w1_idle",  64'(in_ready1),  64'(1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1);
   end

endmodule
